// File: rtl/sram_copy_sequencer_pkg.sv
// Shared register map, bit positions and FSM state type for the SRAM copy sequencer.
package sram_copy_sequencer_pkg;

    localparam int unsigned REG_CORE_ID  = 0;
    localparam int unsigned REG_CTL      = 1;
    localparam int unsigned REG_STATUS   = 2;
    localparam int unsigned REG_SRC_ADDR = 3;
    localparam int unsigned REG_DST_ADDR = 4;
    localparam int unsigned REG_LEN      = 5;
    localparam int unsigned REG_CYCLES   = 6;

    localparam logic [31:0] CORE_ID = 32'h5343_5351;

    localparam int unsigned CTL_START_BIT      = 0;
    localparam int unsigned CTL_ABORT_BIT      = 1;
    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_DONE_BIT    = 1;
    localparam int unsigned STATUS_ABORTED_BIT = 2;

    localparam int unsigned CYCLES_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

endpackage

// File: rtl/sram_copy_sequencer_delay.sv
// Valid-bit delay line matching the source-read plus SPU latency.
module sram_copy_sequencer_delay #(
    parameter int unsigned PIPE_LATENCY = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic beat_in,
    output logic beat_out,
    output logic any_valid
);

    localparam logic [PIPE_LATENCY-1:0] OUT_MASK = PIPE_LATENCY'(1) << (PIPE_LATENCY - 1);

    logic [PIPE_LATENCY-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= PIPE_LATENCY'({valid_q, beat_in});
        end
    end

    assign beat_out  = valid_q[PIPE_LATENCY-1];
    // Beats still in flight once the output stage has been written this cycle.
    assign any_valid = |(valid_q & ~OUT_MASK);

endmodule

// File: rtl/sram_copy_sequencer.sv
// Wishbone-programmed SRAM-to-SRAM copy sequencer issuing source reads and delayed destination writes.
// Optional busy-cycle counter built when SRAM_COPY_SEQUENCER_PERF_EN is defined.
module sram_copy_sequencer
    import sram_copy_sequencer_pkg::*;
#(
    parameter int unsigned WB_ADR_WIDTH    = 8,
    parameter int unsigned WB_DAT_WIDTH    = 64,
    parameter int unsigned WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
    parameter int unsigned SRAM_ADDR_WIDTH = 10,
    parameter int unsigned PIPE_LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WB_ADR_WIDTH-1:0]    s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0]    s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]    s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]    s_wb_sel_i,
    input  logic                       s_wb_we_i,
    input  logic                       s_wb_stb_i,
    output logic                       s_wb_ack_o,
    output logic                       m_src_en,
    output logic [SRAM_ADDR_WIDTH-1:0] m_src_addr,
    output logic                       m_dst_en,
    output logic [SRAM_ADDR_WIDTH-1:0] m_dst_addr,
    output logic                       irq
);

    localparam int unsigned LEN_WIDTH = SRAM_ADDR_WIDTH + 1;

    state_t                     state, state_next;
    logic [SRAM_ADDR_WIDTH-1:0] src_addr, dst_addr, dst_cnt;
    logic [LEN_WIDTH-1:0]       len, issue_cnt;
    logic                       done, aborted, busy;
    logic                       wr_en, ctl_wr, start_req, abort_req, clr_done, clr_aborted;
    logic                       accept_start, set_done, set_aborted, issue_last, pipe_any_valid;
    logic [CYCLES_WIDTH-1:0]    cycles;

    function automatic logic reg_hit(input logic [WB_ADR_WIDTH-1:0] adr, input int unsigned idx);
        return adr == WB_ADR_WIDTH'(idx);
    endfunction

    function automatic logic [WB_DAT_WIDTH-1:0] byte_merge(input logic [WB_DAT_WIDTH-1:0] old_val,
                                                           input logic [WB_DAT_WIDTH-1:0] new_val,
                                                           input logic [WB_SEL_WIDTH-1:0] sel);
        logic [WB_DAT_WIDTH-1:0] r;
        r = old_val;
        for (int unsigned b = 0; b < WB_SEL_WIDTH; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

    assign busy        = (state != IDLE);
    assign wr_en       = s_wb_stb_i && s_wb_we_i;
    assign ctl_wr      = wr_en && reg_hit(s_wb_adr_i, REG_CTL) && s_wb_sel_i[0];
    assign start_req   = ctl_wr && s_wb_dat_i[CTL_START_BIT];
    assign abort_req   = ctl_wr && s_wb_dat_i[CTL_ABORT_BIT];
    assign clr_done    = wr_en && reg_hit(s_wb_adr_i, REG_STATUS) && s_wb_sel_i[0]
                         && s_wb_dat_i[STATUS_DONE_BIT];
    assign clr_aborted = wr_en && reg_hit(s_wb_adr_i, REG_STATUS) && s_wb_sel_i[0]
                         && s_wb_dat_i[STATUS_ABORTED_BIT];
    assign issue_last  = (issue_cnt == LEN_WIDTH'(len - LEN_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks start in the same CTL write; in IDLE that leaves the write with no effect.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        set_done     = 1'b0;
        set_aborted  = 1'b0;
        case (state)
            IDLE: begin
                if (start_req && !abort_req) begin
                    accept_start = 1'b1;
                    if (len == '0) set_done = 1'b1;
                    else           state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_req) begin
                    set_aborted = 1'b1;
                    state_next  = DRAIN;
                end else if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_any_valid) begin
                    set_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            len       <= '0;
            issue_cnt <= '0;
            dst_cnt   <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            if (accept_start) begin
                issue_cnt <= '0;
                dst_cnt   <= '0;
                done      <= set_done;
                aborted   <= 1'b0;
            end else begin
                if (state == ISSUE) issue_cnt <= issue_cnt + LEN_WIDTH'(1);
                if (m_dst_en)       dst_cnt   <= dst_cnt + SRAM_ADDR_WIDTH'(1);
                if (set_done)         done    <= 1'b1;
                else if (clr_done)    done    <= 1'b0;
                if (set_aborted)      aborted <= 1'b1;
                else if (clr_aborted) aborted <= 1'b0;
            end
            if (wr_en && !busy) begin
                if (reg_hit(s_wb_adr_i, REG_SRC_ADDR))
                    src_addr <= SRAM_ADDR_WIDTH'(byte_merge(WB_DAT_WIDTH'(src_addr), s_wb_dat_i, s_wb_sel_i));
                if (reg_hit(s_wb_adr_i, REG_DST_ADDR))
                    dst_addr <= SRAM_ADDR_WIDTH'(byte_merge(WB_DAT_WIDTH'(dst_addr), s_wb_dat_i, s_wb_sel_i));
                if (reg_hit(s_wb_adr_i, REG_LEN))
                    len <= LEN_WIDTH'(byte_merge(WB_DAT_WIDTH'(len), s_wb_dat_i, s_wb_sel_i));
            end
        end
    end

`ifdef SRAM_COPY_SEQUENCER_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycles <= '0;
        end else if (accept_start) begin
            cycles <= '0;
        end else if (busy) begin
            cycles <= cycles + CYCLES_WIDTH'(1);
        end
    end
`else
    assign cycles = '0;
`endif

    sram_copy_sequencer_delay #(
        .PIPE_LATENCY (PIPE_LATENCY)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .beat_in   (m_src_en),
        .beat_out  (m_dst_en),
        .any_valid (pipe_any_valid)
    );

    assign m_src_en   = (state == ISSUE);
    assign m_src_addr = src_addr + issue_cnt[SRAM_ADDR_WIDTH-1:0];
    assign m_dst_addr = dst_addr + dst_cnt;
    assign irq        = done;
    assign s_wb_ack_o = s_wb_stb_i;

    always_comb begin
        s_wb_dat_o = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(REG_CORE_ID):  s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
            WB_ADR_WIDTH'(REG_STATUS): begin
                s_wb_dat_o[STATUS_BUSY_BIT]    = busy;
                s_wb_dat_o[STATUS_DONE_BIT]    = done;
                s_wb_dat_o[STATUS_ABORTED_BIT] = aborted;
            end
            WB_ADR_WIDTH'(REG_SRC_ADDR): s_wb_dat_o = WB_DAT_WIDTH'(src_addr);
            WB_ADR_WIDTH'(REG_DST_ADDR): s_wb_dat_o = WB_DAT_WIDTH'(dst_addr);
            WB_ADR_WIDTH'(REG_LEN):      s_wb_dat_o = WB_DAT_WIDTH'(len);
            WB_ADR_WIDTH'(REG_CYCLES):   s_wb_dat_o = WB_DAT_WIDTH'(cycles);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_copy_sequencer.sv
// Directed self-checking bench for sram_copy_sequencer (default parameters, PIPE_LATENCY=4).
module tb_sram_copy_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  adr;
    logic [63:0] dat_i, dat_o;
    logic [7:0]  sel;
    logic        we, stb, ack;
    logic        src_en, dst_en, irq;
    logic [9:0]  src_addr, dst_addr;

    int tests = 0;
    int failed = 0;

    logic       cap_src_en [1:20];
    logic [9:0] cap_src_addr [1:20];
    logic       cap_dst_en [1:20];
    logic [9:0] cap_dst_addr [1:20];
    logic       cap_irq [1:20];

    localparam logic [7:0] A_ID = 8'd0, A_CTL = 8'd1, A_STATUS = 8'd2, A_SRC = 8'd3;
    localparam logic [7:0] A_DST = 8'd4, A_LEN = 8'd5, A_CYC = 8'd6, A_NONE = 8'd7;

    always #5 clk = ~clk;

    sram_copy_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_wb_adr_i (adr),
        .s_wb_dat_o (dat_o),
        .s_wb_dat_i (dat_i),
        .s_wb_sel_i (sel),
        .s_wb_we_i  (we),
        .s_wb_stb_i (stb),
        .s_wb_ack_o (ack),
        .m_src_en   (src_en),
        .m_src_addr (src_addr),
        .m_dst_en   (dst_en),
        .m_dst_addr (dst_addr),
        .irq        (irq)
    );

    task automatic wb_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
        adr = a; dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [63:0] d);
        adr = a; we = 1'b0; stb = 1'b1;
        #1;
        d = dat_o;
        stb = 1'b0;
        #1;
    endtask

    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_src_en[c] = src_en; cap_src_addr[c] = src_addr;
            cap_dst_en[c] = dst_en; cap_dst_addr[c] = dst_addr;
            cap_irq[c]    = irq;
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        reset_n = 1'b0; adr = A_NONE; dat_i = '0; sel = '0; we = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({src_en, src_addr, dst_en, dst_addr, irq, ack, dat_o} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got src_en=%b src=%h dst_en=%b dst=%h irq=%b ack=%b dat=%h want all 0",
                     src_en, src_addr, dst_en, dst_addr, irq, ack, dat_o);
        end
        wb_read(A_ID, d);
        tests++;
        if (d !== 64'h5343_5351) begin failed++; $display("FAIL core_id got %h want 0000000053435351", d); end
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h0) begin failed++; $display("FAIL reset_status got %h want 0", d); end
    endtask

    task automatic test_registers();
        logic [63:0] d;
        @(posedge clk); #1;
        wb_write(A_SRC, 64'hFFFF, 8'h01);
        wb_read(A_SRC, d);
        tests++;
        if (d !== 64'h0FF) begin failed++; $display("FAIL src_sel_byte0 got %h want 0ff", d); end
        wb_write(A_SRC, 64'h0300, 8'h02);
        wb_read(A_SRC, d);
        tests++;
        if (d !== 64'h3FF) begin failed++; $display("FAIL src_sel_byte1 got %h want 3ff", d); end
        wb_write(A_DST, 64'hABCD, 8'hFF);
        wb_read(A_DST, d);
        tests++;
        if (d !== 64'h3CD) begin failed++; $display("FAIL dst_width got %h want 3cd", d); end
        wb_write(A_LEN, 64'hFFFF, 8'hFF);
        wb_read(A_LEN, d);
        tests++;
        if (d !== 64'h7FF) begin failed++; $display("FAIL len_width got %h want 7ff", d); end
        wb_write(A_NONE, 64'hFFFF_FFFF, 8'hFF);
        wb_read(A_NONE, d);
        tests++;
        if (d !== 64'h0) begin failed++; $display("FAIL unmapped got %h want 0", d); end
        wb_read(A_CTL, d);
        tests++;
        if (d !== 64'h0) begin failed++; $display("FAIL ctl_read got %h want 0", d); end
        wb_read(A_CYC, d);
        tests++;
        if (d !== 64'h0) begin failed++; $display("FAIL cycles_reset got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [63:0] d, exp_cyc;
        logic        e_src, e_dst;
        @(posedge clk); #1;
        wb_write(A_SRC, 64'h010, 8'hFF);
        wb_write(A_DST, 64'h200, 8'hFF);
        wb_write(A_LEN, 64'd8, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        capture(13);
        for (int c = 1; c <= 13; c++) begin
            e_src = (c <= 8);
            e_dst = (c >= 5 && c <= 12);
            tests++;
            if (cap_src_en[c] !== e_src || cap_dst_en[c] !== e_dst || cap_irq[c] !== (c == 13)) begin
                failed++;
                $display("FAIL basic_enables cycle %0d got src=%b dst=%b irq=%b want %b %b %b",
                         c, cap_src_en[c], cap_dst_en[c], cap_irq[c], e_src, e_dst, c == 13);
            end
            if (e_src) begin
                tests++;
                if (cap_src_addr[c] !== 10'(16'h010 + c - 1)) begin
                    failed++; $display("FAIL basic_src_addr cycle %0d got %h", c, cap_src_addr[c]);
                end
            end
            if (e_dst) begin
                tests++;
                if (cap_dst_addr[c] !== 10'(16'h200 + c - 5)) begin
                    failed++; $display("FAIL basic_dst_addr cycle %0d got %h", c, cap_dst_addr[c]);
                end
            end
        end
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h2) begin failed++; $display("FAIL basic_status got %h want 2", d); end
`ifdef SRAM_COPY_SEQUENCER_PERF_EN
        exp_cyc = 64'd12;
`else
        exp_cyc = 64'd0;
`endif
        wb_read(A_CYC, d);
        tests++;
        if (d !== exp_cyc) begin failed++; $display("FAIL basic_cycles got %0d want %0d", d, exp_cyc); end
    endtask

    task automatic test_len_zero();
        logic [63:0] d;
        int pulses;
        @(posedge clk); #1;
        wb_write(A_STATUS, 64'h6, 8'h01);
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h0 || irq !== 1'b0) begin
            failed++; $display("FAIL clear_done got status=%h irq=%b want 0 0", d, irq);
        end
        wb_write(A_LEN, 64'd0, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        capture(6);
        pulses = 0;
        for (int c = 1; c <= 6; c++) pulses += int'(cap_src_en[c]) + int'(cap_dst_en[c]);
        tests++;
        if (pulses != 0) begin failed++; $display("FAIL len0_pulses got %0d want 0", pulses); end
        tests++;
        if (cap_irq[1] !== 1'b1) begin failed++; $display("FAIL len0_done got irq=%b want 1", cap_irq[1]); end
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h2) begin failed++; $display("FAIL len0_status got %h want 2", d); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_src [1:4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        logic [9:0] exp_dst [1:4] = '{10'h3FF, 10'h000, 10'h001, 10'h002};
        @(posedge clk); #1;
        wb_write(A_SRC, 64'h3FE, 8'hFF);
        wb_write(A_DST, 64'h3FF, 8'hFF);
        wb_write(A_LEN, 64'd4, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        capture(9);
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (cap_src_en[i] !== 1'b1 || cap_src_addr[i] !== exp_src[i]) begin
                failed++; $display("FAIL wrap_src beat %0d got en=%b addr=%h want 1 %h",
                                   i, cap_src_en[i], cap_src_addr[i], exp_src[i]);
            end
            tests++;
            if (cap_dst_en[i+4] !== 1'b1 || cap_dst_addr[i+4] !== exp_dst[i]) begin
                failed++; $display("FAIL wrap_dst beat %0d got en=%b addr=%h want 1 %h",
                                   i, cap_dst_en[i+4], cap_dst_addr[i+4], exp_dst[i]);
            end
        end
        tests++;
        if (cap_src_en[5] !== 1'b0 || cap_dst_en[9] !== 1'b0 || cap_irq[8] !== 1'b0 || cap_irq[9] !== 1'b1) begin
            failed++; $display("FAIL wrap_end got src5=%b dst9=%b irq8=%b irq9=%b want 0 0 0 1",
                               cap_src_en[5], cap_dst_en[9], cap_irq[8], cap_irq[9]);
        end
    endtask

    task automatic test_abort();
        logic [63:0] d;
        int writes;
        @(posedge clk); #1;
        wb_write(A_SRC, 64'h040, 8'hFF);
        wb_write(A_DST, 64'h100, 8'hFF);
        wb_write(A_LEN, 64'd16, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        fork
            capture(14);
            begin
                repeat (4) @(posedge clk);
                #1;
                wb_write(A_CTL, 64'h2, 8'h01);
            end
        join
        writes = 0;
        for (int c = 1; c <= 14; c++) begin
            writes += int'(cap_dst_en[c]);
            tests++;
            if (cap_src_en[c] !== (c <= 5) || cap_dst_en[c] !== (c >= 5 && c <= 9) || cap_irq[c] !== (c >= 10)) begin
                failed++; $display("FAIL abort_enables cycle %0d got src=%b dst=%b irq=%b",
                                   c, cap_src_en[c], cap_dst_en[c], cap_irq[c]);
            end
            if (c >= 5 && c <= 9) begin
                tests++;
                if (cap_dst_addr[c] !== 10'(16'h100 + c - 5)) begin
                    failed++; $display("FAIL abort_dst_addr cycle %0d got %h", c, cap_dst_addr[c]);
                end
            end
        end
        tests++;
        if (writes != 5) begin failed++; $display("FAIL abort_write_count got %0d want 5", writes); end
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h6) begin failed++; $display("FAIL abort_status got %h want 6", d); end
        @(posedge clk); #1;
        wb_write(A_STATUS, 64'h6, 8'h01);
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h0 || irq !== 1'b0) begin
            failed++; $display("FAIL abort_w1c got status=%h irq=%b want 0 0", d, irq);
        end
    endtask

    task automatic test_busy_writes();
        logic [63:0] d, exp_cyc;
        @(posedge clk); #1;
        wb_write(A_SRC, 64'h020, 8'hFF);
        wb_write(A_DST, 64'h300, 8'hFF);
        wb_write(A_LEN, 64'd6, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        fork
            capture(12);
            begin
                wb_read(A_STATUS, d);
                tests++;
                if (d !== 64'h1) begin failed++; $display("FAIL busy_status got %h want 1", d); end
                wb_write(A_LEN, 64'd3, 8'hFF);
                wb_write(A_CTL, 64'h1, 8'h01);
                wb_read(A_LEN, d);
                tests++;
                if (d !== 64'd6) begin failed++; $display("FAIL busy_len_write got %0d want 6", d); end
            end
        join
        for (int c = 1; c <= 12; c++) begin
            tests++;
            if (cap_src_en[c] !== (c <= 6) || cap_dst_en[c] !== (c >= 5 && c <= 10) || cap_irq[c] !== (c >= 11)) begin
                failed++; $display("FAIL busy_enables cycle %0d got src=%b dst=%b irq=%b",
                                   c, cap_src_en[c], cap_dst_en[c], cap_irq[c]);
            end
            if (c <= 6) begin
                tests++;
                if (cap_src_addr[c] !== 10'(16'h020 + c - 1)) begin
                    failed++; $display("FAIL busy_src_addr cycle %0d got %h", c, cap_src_addr[c]);
                end
            end
        end
`ifdef SRAM_COPY_SEQUENCER_PERF_EN
        exp_cyc = 64'd10;
`else
        exp_cyc = 64'd0;
`endif
        wb_read(A_CYC, d);
        tests++;
        if (d !== exp_cyc) begin failed++; $display("FAIL busy_cycles got %0d want %0d", d, exp_cyc); end
    endtask

    task automatic test_start_abort_same();
        logic [63:0] d;
        int pulses;
        @(posedge clk); #1;
        wb_write(A_LEN, 64'd5, 8'hFF);
        wb_write(A_CTL, 64'h3, 8'h01);
        capture(8);
        pulses = 0;
        for (int c = 1; c <= 8; c++) pulses += int'(cap_src_en[c]) + int'(cap_dst_en[c]) + int'(!cap_irq[c]);
        tests++;
        if (pulses != 0) begin failed++; $display("FAIL start_abort_activity got %0d events want 0", pulses); end
        wb_read(A_STATUS, d);
        tests++;
        if (d !== 64'h2) begin failed++; $display("FAIL start_abort_status got %h want 2", d); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        int pulses;
        @(posedge clk); #1;
        wb_write(A_SRC, 64'h080, 8'hFF);
        wb_write(A_DST, 64'h180, 8'hFF);
        wb_write(A_LEN, 64'd16, 8'hFF);
        wb_write(A_CTL, 64'h1, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0; adr = A_STATUS;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({src_en, src_addr, dst_en, dst_addr, irq, ack, dat_o} !== '0) begin
            failed++;
            $display("FAIL reset_mid_outputs got src_en=%b src=%h dst_en=%b dst=%h irq=%b ack=%b dat=%h want all 0",
                     src_en, src_addr, dst_en, dst_addr, irq, ack, dat_o);
        end
        wb_read(A_SRC, d);
        tests++;
        if (d !== 64'h0) begin failed++; $display("FAIL reset_mid_src got %h want 0", d); end
        capture(10);
        pulses = 0;
        for (int c = 1; c <= 10; c++) pulses += int'(cap_src_en[c]) + int'(cap_dst_en[c]);
        tests++;
        if (pulses != 0) begin failed++; $display("FAIL reset_mid_enables got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_basic();
        test_len_zero();
        test_wrap();
        test_abort();
        test_busy_writes();
        test_start_abort_same();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sram_copy_sequencer.md
# sram_copy_sequencer

Wishbone-controlled sequencer for the SRAM-to-SRAM SPU evaluation datapath. Software programs the source address, destination address and length. The block then issues one source-SRAM read per cycle. It issues the matching destination-SRAM write after the fixed read-plus-SPU pipeline latency. The block sits between the design's Wishbone slave bus and the SRAM read/write control ports. The data path itself (src dout → SPU → dst din) is wired outside the block.

## Interface
- WB_ADR_WIDTH, 8: Wishbone word-address width.
- WB_DAT_WIDTH, 64: Wishbone data width.
- WB_SEL_WIDTH, WB_DAT_WIDTH/8: byte-select width.
- SRAM_ADDR_WIDTH, 10: SRAM word-address width.
- PIPE_LATENCY, 4: cycles from m_src_en to the matching m_dst_en; range 1..16.
- clk  in  1  single clock for the whole block.
- reset_n  in  1  synchronous, active-low reset.
- s_wb_adr_i  in  WB_ADR_WIDTH  register word index.
- s_wb_dat_o  out  WB_DAT_WIDTH  read data.
- s_wb_dat_i  in  WB_DAT_WIDTH  write data.
- s_wb_sel_i  in  WB_SEL_WIDTH  byte enables.
- s_wb_we_i  in  1  write strobe qualifier.
- s_wb_stb_i  in  1  access strobe.
- s_wb_ack_o  out  1  access acknowledge.
- m_src_en  out  1  source SRAM read enable.
- m_src_addr  out  SRAM_ADDR_WIDTH  source SRAM read address.
- m_dst_en  out  1  destination SRAM write enable.
- m_dst_addr  out  SRAM_ADDR_WIDTH  destination SRAM write address.
- irq  out  1  level; equals STATUS.done.

## Operation
- Registers (word index):
  - 0 CORE_ID: RO, 0x5343_5351.
  - 1 CTL: bit0 start, bit1 abort. Both are write-1 pulses and always read 0.
  - 2 STATUS: bit0 busy (RO), bit1 done (sticky, write-1-clear), bit2 aborted (sticky, write-1-clear).
  - 3 SRC_ADDR.
  - 4 DST_ADDR.
  - 5 LEN, in words, SRAM_ADDR_WIDTH+1 bits.
  - 6 CYCLES (see Configuration).
  - Unmapped indices read 0 and ignore writes. Writes honour s_wb_sel_i per byte.
- SRC_ADDR, DST_ADDR and LEN writes are ignored while busy. A start while busy is ignored.
- State machine with three states: IDLE, ISSUE, DRAIN.
  - IDLE, start with LEN=0: set done, make no SRAM access, stay in IDLE.
  - IDLE, start with LEN>0: latch addresses and length, go to ISSUE. Writing start also clears done and aborted.
  - ISSUE:
    - m_src_en=1 every cycle.
    - m_src_addr = SRC_ADDR+i, modulo 2^SRAM_ADDR_WIDTH (wraps silently).
    - After beat LEN-1, go to DRAIN.
  - ISSUE, abort: stop issuing from the next cycle, set aborted, go to DRAIN.
  - DRAIN: wait until the delay line holds no valid beats, then set done and go to IDLE.
- Each issued beat enters a PIPE_LATENCY-deep valid delay line.
  - Its output drives m_dst_en.
  - m_dst_addr = DST_ADDR+j, where j counts completed writes; wraps like the source address.
  - In-flight beats are never cancelled by abort.
- Abort in IDLE or DRAIN has no effect.
- Start and abort in the same write: abort wins. No transfer starts and no flags change.

## Timing
- s_wb_ack_o = s_wb_stb_i (combinational, zero wait states).
  - s_wb_dat_o is combinational from s_wb_adr_i.
  - Writes take effect on the clk edge where s_wb_stb_i&s_wb_we_i.
- Start written at edge T:
  - busy=1 from cycle T+1.
  - First m_src_en in cycle T+1; last in cycle T+LEN.
  - m_dst_en for beat i in cycle T+1+i+PIPE_LATENCY.
  - Last write in cycle T+LEN+PIPE_LATENCY.
  - done=1, busy=0 and irq=1 from cycle T+LEN+PIPE_LATENCY+1.
- Reset values: all outputs 0; all registers 0; state IDLE; delay line empty.
- Reset mid-transfer: all activity stops at the next edge and no further SRAM enables are issued.

## Configuration
- SRAM_COPY_SEQUENCER_PERF_EN defined:
  - CYCLES (index 6, RO) counts clk cycles while busy.
  - It clears on an accepted start and holds after completion.
  - For an unaborted transfer it reads LEN+PIPE_LATENCY.
- SRAM_COPY_SEQUENCER_PERF_EN undefined: the counter is not built and index 6 reads 0.

## Structure
- Package sram_copy_sequencer_pkg contains:
  - register index localparams;
  - CORE_ID constant;
  - STATUS/CTL bit positions;
  - state enum typedef (IDLE, ISSUE, DRAIN).
- Sub-module sram_copy_sequencer_delay: parameterised PIPE_LATENCY valid shift register with synchronous active-low reset and an "any valid" output, used by the DRAIN exit condition.

## Test plan
- SRC=0x010, DST=0x200, LEN=8, PIPE_LATENCY=4, start at T:
  - src reads 0x010..0x017 in cycles T+1..T+8;
  - dst writes 0x200..0x207 in cycles T+5..T+12;
  - done=1 and irq=1 at T+13; CYCLES=12 when PERF_EN is defined.
- LEN=0 start → done=1 the next cycle; no m_src_en or m_dst_en pulses.
- SRC=0x3FE, DST=0x3FF, LEN=4 → src addresses 0x3FE,0x3FF,0x000,0x001; dst addresses 0x3FF,0x000,0x001,0x002.
- LEN=16, abort after 5 reads → exactly 5 writes, then done=1 and aborted=1. Writing 0x6 to STATUS clears both flags and drops irq.
- While busy:
  - write LEN=3 and a second start → ignored; the original transfer completes unchanged;
  - STATUS reads busy=1.
- reset_n low for one cycle mid-ISSUE → the next cycle has all outputs 0 and STATUS=0, with no further SRAM enables.
